// File: rtl/tomasulo_pkg.sv
// -----------------------------------------------------------------------------
// tomasulo_pkg
//   Shared definitions for the Tomasulo functional units and the reservation
//   stations: data/tag widths, opcode encodings and the functional-unit state
//   encoding.
//
//   Contents:
//     DATA_W, TAG_W, OP_W        - datapath, tag and opcode widths
//     OP_ADD, OP_SUB             - opcodes handled by the add/sub unit
//     fu_state_t + ST_* values   - functional-unit FSM state encoding
//     is_add_sub_op()            - opcode filter used at dispatch
// -----------------------------------------------------------------------------
package tomasulo_pkg;

  localparam int DATA_W = 16;
  localparam int TAG_W  = 4;
  localparam int OP_W   = 3;

  localparam logic [OP_W-1:0] OP_ADD = 3'b001;
  localparam logic [OP_W-1:0] OP_SUB = 3'b010;

  // Plain logic vector plus named constants so older code that compares
  // against raw encodings keeps working.
  typedef logic [1:0] fu_state_t;

  localparam fu_state_t ST_IDLE     = 2'd0;
  localparam fu_state_t ST_EXEC     = 2'd1;
  localparam fu_state_t ST_WAIT_CDB = 2'd2;

  function automatic logic is_add_sub_op(input logic [OP_W-1:0] o);
    return (o == OP_ADD) || (o == OP_SUB);
  endfunction

endpackage

// File: rtl/add_sub_unit.sv
// -----------------------------------------------------------------------------
// add_sub_unit
//   Integer add/subtract functional unit for a Tomasulo pipeline. Accepts one
//   instruction from a reservation station, spends LATENCY cycles executing,
//   then requests the common data bus (CDB) and broadcasts tag + result once
//   granted.
//
//   Parameter:
//     LATENCY    execute cycles from accept to CDB request (legal 1..7)
//
//   Ports:
//     CLK        clock, rising edge
//     CLR        asynchronous active-high reset
//     start      dispatch strobe from the reservation station
//     op         opcode (OP_ADD / OP_SUB; anything else is ignored)
//     Vj, Vk     source operands
//     tag        reservation-station tag of the dispatched instruction
//     busy       unit holds an instruction, dispatch is not accepted
//     cdb_req    CDB request, high exactly while waiting for the bus
//     cdb_grant  CDB arbiter grant
//     cdb_valid  one-cycle result broadcast
//     cdb_tag    broadcast tag (0 when cdb_valid is low)
//     cdb_data   broadcast result (0 when cdb_valid is low)
//     dbg_state  current FSM state (ST_IDLE / ST_EXEC / ST_WAIT_CDB)
//     cdb_ovf    signed overflow of the broadcast result
//                (only when ADD_SUB_UNIT_OVF_EN is defined)
//
//   Handshakes:
//     Dispatch: the rising edge with start=1, busy=0 and a legal op is the
//     transfer; busy plays the role of an inverted ready. Result: cdb_req is
//     the valid, cdb_grant the ready; a rising edge with both high transfers
//     the result, which appears on cdb_valid/cdb_tag/cdb_data for the
//     following cycle. cdb_req stays high and the result stays held until that
//     edge; cdb_grant is meaningless while cdb_req is low.
// -----------------------------------------------------------------------------
module add_sub_unit
  import tomasulo_pkg::*;
#(
  parameter int LATENCY = 2
) (
  input  logic              CLK,
  input  logic              CLR,
  input  logic              start,
  input  logic [OP_W-1:0]   op,
  input  logic [DATA_W-1:0] Vj,
  input  logic [DATA_W-1:0] Vk,
  input  logic [TAG_W-1:0]  tag,
  output logic              busy,
  output logic              cdb_req,
  input  logic              cdb_grant,
  output logic              cdb_valid,
  output logic [TAG_W-1:0]  cdb_tag,
  output logic [DATA_W-1:0] cdb_data,
  output logic [1:0]        dbg_state
`ifdef ADD_SUB_UNIT_OVF_EN
  ,
  output logic              cdb_ovf
`endif
);

  // The counter counts down to 0 inside EXEC; loading LATENCY-1 makes the
  // unit spend exactly LATENCY cycles in EXEC.
  localparam logic [2:0] CNT_LOAD = 3'(LATENCY - 1);

  fu_state_t         state;
  logic [2:0]        cnt;
  logic [OP_W-1:0]   op_q;
  logic [DATA_W-1:0] vj_q;
  logic [DATA_W-1:0] vk_q;
  logic [TAG_W-1:0]  tag_q;
  logic [DATA_W-1:0] result;
  logic              accept;

  // Carry/borrow out of bit 15 is simply dropped.
  always_comb begin
    result = '0;
    if (op_q == OP_SUB) result = vj_q - vk_q;
    else                result = vj_q + vk_q;
  end

`ifdef ADD_SUB_UNIT_OVF_EN
  // Two's-complement overflow: operands that push in the same signed
  // direction (for SUB, Vk's sign is effectively inverted) but produce a
  // result whose sign differs from Vj.
  logic ovf_c;
  always_comb begin
    ovf_c = 1'b0;
    if (op_q == OP_SUB)
      ovf_c = (vj_q[DATA_W-1] != vk_q[DATA_W-1]) && (result[DATA_W-1] != vj_q[DATA_W-1]);
    else
      ovf_c = (vj_q[DATA_W-1] == vk_q[DATA_W-1]) && (result[DATA_W-1] != vj_q[DATA_W-1]);
  end
`endif

  assign accept    = (state == ST_IDLE) && start && is_add_sub_op(op);
  assign busy      = (state != ST_IDLE);
  assign cdb_req   = (state == ST_WAIT_CDB);
  assign dbg_state = state;

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      op_q      <= '0;
      vj_q      <= '0;
      vk_q      <= '0;
      tag_q     <= '0;
      cdb_valid <= 1'b0;
      cdb_tag   <= '0;
      cdb_data  <= '0;
`ifdef ADD_SUB_UNIT_OVF_EN
      cdb_ovf   <= 1'b0;
`endif
    end else begin
      // Broadcast outputs are a one-cycle pulse and read as zero otherwise.
      cdb_valid <= 1'b0;
      cdb_tag   <= '0;
      cdb_data  <= '0;
`ifdef ADD_SUB_UNIT_OVF_EN
      cdb_ovf   <= 1'b0;
`endif
      case (state)
        ST_IDLE: begin
          if (accept) begin
            op_q  <= op;
            vj_q  <= Vj;
            vk_q  <= Vk;
            tag_q <= tag;
            cnt   <= CNT_LOAD;
            state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (cnt == 3'd0) state <= ST_WAIT_CDB;
          else             cnt   <= cnt - 3'd1;
        end
        ST_WAIT_CDB: begin
          if (cdb_grant) begin
            cdb_valid <= 1'b1;
            cdb_tag   <= tag_q;
            cdb_data  <= result;
`ifdef ADD_SUB_UNIT_OVF_EN
            cdb_ovf   <= ovf_c;
`endif
            // Returning to IDLE here lets a new dispatch land in the same
            // cycle the broadcast is visible.
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_add_sub_unit.sv
module tb_add_sub_unit;
  import tomasulo_pkg::*;

  localparam int LATENCY = 2;
  localparam int W = 1 + TAG_W + DATA_W;   // {ovf, tag, data}

  // ---------------------------------------------------------------- clock/reset
  logic              CLK = 1'b0;
  logic              CLR;
  logic              start;
  logic [OP_W-1:0]   op;
  logic [DATA_W-1:0] Vj, Vk;
  logic [TAG_W-1:0]  tag;
  logic              busy, cdb_req, cdb_grant, cdb_valid;
  logic [TAG_W-1:0]  cdb_tag;
  logic [DATA_W-1:0] cdb_data;
  logic [1:0]        dbg_state;
`ifdef ADD_SUB_UNIT_OVF_EN
  logic              cdb_ovf;
`endif

  always #5 CLK = ~CLK;

  add_sub_unit #(.LATENCY(LATENCY)) dut (
    .CLK(CLK), .CLR(CLR), .start(start), .op(op), .Vj(Vj), .Vk(Vk), .tag(tag),
    .busy(busy), .cdb_req(cdb_req), .cdb_grant(cdb_grant),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .dbg_state(dbg_state)
`ifdef ADD_SUB_UNIT_OVF_EN
    , .cdb_ovf(cdb_ovf)
`endif
  );

  // ---------------------------------------------------------------- scoreboard
  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] mon_e;
  bit mon_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Every broadcast is matched against the oldest expected result; outside a
  // broadcast tag/data must read zero.
  always @(negedge CLK) begin
    if (mon_en && !CLR) begin
      if (cdb_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_bcast: got tag %0h data %0h expected no broadcast", cdb_tag, cdb_data);
        end else begin
          mon_e = exp_q.pop_front();
          chk("bcast_tag", 32'(cdb_tag), 32'(mon_e[DATA_W +: TAG_W]));
          chk("bcast_data", 32'(cdb_data), 32'(mon_e[DATA_W-1:0]));
`ifdef ADD_SUB_UNIT_OVF_EN
          chk("bcast_ovf", 32'(cdb_ovf), 32'(mon_e[W-1]));
`endif
        end
      end else begin
        chk("idle_tag_zero", 32'(cdb_tag), 32'd0);
        chk("idle_data_zero", 32'(cdb_data), 32'd0);
`ifdef ADD_SUB_UNIT_OVF_EN
        chk("idle_ovf_zero", 32'(cdb_ovf), 32'd0);
`endif
      end
    end
  end

  // ---------------------------------------------------------------- drivers
  typedef struct {
    logic [OP_W-1:0]   op;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [TAG_W-1:0]  t;
    logic [DATA_W-1:0] d;
    logic              v;
  } vec_t;

  vec_t vecs[7];

  // Called at a negedge: drives one dispatch cycle, returns at the next negedge.
  task automatic drive_start(input logic [OP_W-1:0] o, input logic [DATA_W-1:0] a,
                             input logic [DATA_W-1:0] b, input logic [TAG_W-1:0] t,
                             input logic [DATA_W-1:0] d, input logic v, input logic push);
    start = 1'b1; op = o; Vj = a; Vk = b; tag = t;
    if (push) exp_q.push_back({v, t, d});
    @(negedge CLK);
    start = 1'b0; op = '0; Vj = '0; Vk = '0; tag = '0;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge CLK);
    while (busy !== 1'b0 && n < 50) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 50) begin
      checks++; errors++;
      $display("FAIL wait_idle_timeout: busy %0b expected 0", busy);
    end
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge CLK);
      n++;
    end
    chk("drain_queue_empty", 32'(exp_q.size()), 32'd0);
  endtask

  // Full transaction with grant held high: checks the exact request latency
  // and the one-cycle broadcast.
  task automatic run_vec(input vec_t x);
    wait_idle();
    drive_start(x.op, x.a, x.b, x.t, x.d, x.v, 1'b1);
    chk("busy_after_accept", 32'(busy), 32'd1);
    chk("req_low_after_accept", 32'(cdb_req), 32'd0);
    for (int k = 1; k < LATENCY; k++) begin
      @(negedge CLK);
      chk("req_low_in_exec", 32'(cdb_req), 32'd0);
    end
    @(negedge CLK);
    chk("req_at_latency", 32'(cdb_req), 32'd1);
    @(negedge CLK);
    chk("valid_pulse", 32'(cdb_valid), 32'd1);
    chk("busy_drop_with_valid", 32'(busy), 32'd0);
    chk("req_drop_with_valid", 32'(cdb_req), 32'd0);
    @(negedge CLK);
    chk("valid_one_cycle", 32'(cdb_valid), 32'd0);
  endtask

  task automatic chk_all_zero(input string pfx);
    chk({pfx, "_busy"}, 32'(busy), 32'd0);
    chk({pfx, "_req"}, 32'(cdb_req), 32'd0);
    chk({pfx, "_valid"}, 32'(cdb_valid), 32'd0);
    chk({pfx, "_tag"}, 32'(cdb_tag), 32'd0);
    chk({pfx, "_data"}, 32'(cdb_data), 32'd0);
    chk({pfx, "_state"}, 32'(dbg_state), 32'(ST_IDLE));
`ifdef ADD_SUB_UNIT_OVF_EN
    chk({pfx, "_ovf"}, 32'(cdb_ovf), 32'd0);
`endif
  endtask

  // ---------------------------------------------------------------- watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------- test
  initial begin
    int n;
    start = 0; op = '0; Vj = '0; Vk = '0; tag = '0; cdb_grant = 0;
    CLR = 1'b1;

    vecs[0] = '{OP_ADD, 16'h0003, 16'h0004, 4'h5, 16'h0007, 1'b0};
    vecs[1] = '{OP_SUB, 16'h0000, 16'h0001, 4'h3, 16'hFFFF, 1'b0};
    vecs[2] = '{OP_ADD, 16'h7FFF, 16'h0001, 4'h1, 16'h8000, 1'b1};
    vecs[3] = '{OP_SUB, 16'h8000, 16'h0001, 4'h2, 16'h7FFF, 1'b1};
    vecs[4] = '{OP_ADD, 16'hFFFF, 16'h0001, 4'hA, 16'h0000, 1'b0};
    vecs[5] = '{OP_SUB, 16'h1234, 16'h0234, 4'hF, 16'h1000, 1'b0};
    vecs[6] = '{OP_ADD, 16'h8000, 16'h8000, 4'hE, 16'h0000, 1'b1};

    repeat (3) @(negedge CLK);
    chk_all_zero("in_reset");
    CLR = 1'b0;
    @(negedge CLK);
    chk_all_zero("after_reset");
    mon_en = 1'b1;

    // Table of basic transactions, grant held high.
    cdb_grant = 1'b1;
    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // Grant withheld for 5 cycles after the request rises.
    cdb_grant = 1'b0;
    wait_idle();
    drive_start(OP_ADD, 16'h0100, 16'h0020, 4'h6, 16'h0120, 1'b0, 1'b1);
    repeat (LATENCY) @(negedge CLK);
    chk("hold_req_rise", 32'(cdb_req), 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      chk("hold_req", 32'(cdb_req), 32'd1);
      chk("hold_busy", 32'(busy), 32'd1);
      chk("hold_no_valid", 32'(cdb_valid), 32'd0);
      chk("hold_state", 32'(dbg_state), 32'(ST_WAIT_CDB));
    end
    cdb_grant = 1'b1;
    @(negedge CLK);
    chk("hold_valid_on_grant", 32'(cdb_valid), 32'd1);
    @(negedge CLK);
    chk("hold_single_pulse", 32'(cdb_valid), 32'd0);

    // Grant while idle must not produce anything.
    repeat (4) begin
      @(negedge CLK);
      chk("grant_idle_no_valid", 32'(cdb_valid), 32'd0);
      chk("grant_idle_no_busy", 32'(busy), 32'd0);
    end

    // Illegal opcodes in IDLE, then a start while busy.
    drive_start(3'b011, 16'h0005, 16'h0005, 4'h2, 16'h0000, 1'b0, 1'b0);
    chk("illegal_op_011_busy", 32'(busy), 32'd0);
    chk("illegal_op_011_state", 32'(dbg_state), 32'(ST_IDLE));
    drive_start(3'b000, 16'h0005, 16'h0005, 4'h2, 16'h0000, 1'b0, 1'b0);
    chk("illegal_op_000_busy", 32'(busy), 32'd0);
    drive_start(OP_ADD, 16'h0011, 16'h0022, 4'h7, 16'h0033, 1'b0, 1'b1);
    chk("busy_first_accept", 32'(busy), 32'd1);
    drive_start(OP_SUB, 16'h0F00, 16'h0001, 4'h8, 16'h0EFF, 1'b0, 1'b0);
    chk("busy_start_ignored", 32'(busy), 32'd1);
    drain();
    repeat (LATENCY + 3) @(negedge CLK);
    chk("busy_start_no_second", 32'(busy), 32'd0);

    // Reset during EXEC.
    cdb_grant = 1'b1;
    wait_idle();
    drive_start(OP_ADD, 16'h1111, 16'h2222, 4'hC, 16'h3333, 1'b0, 1'b0);
    chk("pre_clr_exec_state", 32'(dbg_state), 32'(ST_EXEC));
    CLR = 1'b1;
    #1;
    chk_all_zero("clr_exec");
    @(negedge CLK);
    CLR = 1'b0;
    repeat (LATENCY + 4) begin
      @(negedge CLK);
      chk("clr_exec_no_bcast", 32'(cdb_valid), 32'd0);
    end
    run_vec('{OP_ADD, 16'h00FF, 16'h0001, 4'hD, 16'h0100, 1'b0});

    // Reset during WAIT_CDB.
    cdb_grant = 1'b0;
    wait_idle();
    drive_start(OP_SUB, 16'h0050, 16'h0010, 4'hB, 16'h0040, 1'b0, 1'b0);
    repeat (LATENCY) @(negedge CLK);
    chk("pre_clr_wait_req", 32'(cdb_req), 32'd1);
    CLR = 1'b1;
    #1;
    chk_all_zero("clr_wait");
    @(negedge CLK);
    CLR = 1'b0;
    cdb_grant = 1'b1;
    repeat (LATENCY + 4) begin
      @(negedge CLK);
      chk("clr_wait_no_bcast", 32'(cdb_valid), 32'd0);
    end

    // Back-to-back dispatch in the broadcast cycle.
    wait_idle();
    drive_start(OP_ADD, 16'h0002, 16'h0002, 4'h4, 16'h0004, 1'b0, 1'b1);
    n = 0;
    while (cdb_valid !== 1'b1 && n < 20) begin
      @(negedge CLK);
      n++;
    end
    chk("b2b_first_valid", 32'(cdb_valid), 32'd1);
    drive_start(OP_SUB, 16'h0010, 16'h0003, 4'h9, 16'h000D, 1'b0, 1'b1);
    chk("b2b_accepted", 32'(busy), 32'd1);
    repeat (LATENCY) @(negedge CLK);
    chk("b2b_req_at_latency", 32'(cdb_req), 32'd1);
    @(negedge CLK);
    chk("b2b_second_valid", 32'(cdb_valid), 32'd1);
    drain();

    repeat (2) @(negedge CLK);
    mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
